// File: rtl/nios_jtag_dbg_pkg.sv
// Shared constants and virtual-JTAG instruction encodings for the Nios debug
// system-clock decoder.
package nios_jtag_dbg_pkg;

    localparam int SR_W_DEF        = 38;
    localparam int IR_W_DEF        = 2;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int DEPTH_DEF       = 4;
    localparam int TAKE_BIT_DEF    = 34;

    typedef enum logic [1:0] {
        IR_OCIMEM    = 2'd0,
        IR_TRACEMEM  = 2'd1,
        IR_BREAK     = 2'd2,
        IR_TRACECTRL = 2'd3
    } ir_e;

endpackage

// File: rtl/nios_jtag_dbg_act_fifo.sv
// Show-ahead action FIFO. A push into a full FIFO without a same-cycle pop is
// dropped and flagged so the caller can record the overflow.
module nios_jtag_dbg_act_fifo #(
    parameter int W     = 40,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop_req,
    output logic                     head_valid,
    output logic [W-1:0]             head_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     drop
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         empty;
    logic         full;
    logic         pop;
    logic         wr_en;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign level      = wr_ptr - rd_ptr;
    assign empty      = (level == '0);
    assign full       = (level == FULL_LVL);
    assign pop        = pop_req && !empty;
    assign drop       = push && full && !pop;
    assign wr_en      = push && !drop;
    assign head_valid = !empty;
    assign head_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/nios_jtag_debug_sysclk_dec.sv
// Brings virtual-JTAG update-DR/update-IR strobes into the system clock domain
// and queues each captured {ir, sr} as an action for the debug core.
module nios_jtag_debug_sysclk_dec
    import nios_jtag_dbg_pkg::*;
#(
    parameter int SR_W        = SR_W_DEF,
    parameter int IR_W        = IR_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DEPTH       = DEPTH_DEF,
    parameter int TAKE_BIT    = TAKE_BIT_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [SR_W-1:0]            sr,
    input  logic [IR_W-1:0]            ir_in,
    input  logic                       vs_udr,
    input  logic                       vs_uir,
    input  logic                       act_ready,
    input  logic                       ovf_clr,
    output logic [SR_W-1:0]            jdo,
    output logic                       act_valid,
    output logic [IR_W-1:0]            act_ir,
    output logic [SR_W-1:0]            act_jdo,
    output logic                       act_take,
    output logic                       ir_upd,
    output logic                       ovf,
    output logic [$clog2(DEPTH):0]     level
);

    logic [SYNC_STAGES-1:0] udr_sync;
    logic [SYNC_STAGES-1:0] uir_sync;
    logic [SYNC_STAGES-1:0] fill;
    logic [1:0]             synced;
    logic [1:0]             prev;
    logic [1:0]             armed;
    logic [1:0]             evt;
    logic                   drop;
    logic [IR_W+SR_W-1:0]   head_data;

    assign synced = {uir_sync[SYNC_STAGES-1], udr_sync[SYNC_STAGES-1]};
    assign evt    = armed & synced & ~prev;

    // fill marks when the chains hold real input rather than reset zeros, so a
    // level held high across reset release never looks like a rising edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            udr_sync <= '0;
            uir_sync <= '0;
            fill     <= '0;
            prev     <= '0;
            armed    <= '0;
        end else begin
            udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
            uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
            fill     <= {fill[SYNC_STAGES-2:0], 1'b1};
            prev     <= synced;
            if (fill[SYNC_STAGES-1]) armed <= armed | ~synced;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            jdo    <= '0;
            ir_upd <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            ir_upd <= evt[1];
            if (evt[0] && !drop) jdo <= sr;
            if (drop)            ovf <= 1'b1;
            else if (ovf_clr)    ovf <= 1'b0;
        end
    end

    nios_jtag_dbg_act_fifo #(
        .W     (IR_W + SR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (evt[0]),
        .push_data  ({ir_in, sr}),
        .pop_req    (act_ready),
        .head_valid (act_valid),
        .head_data  (head_data),
        .level      (level),
        .drop       (drop)
    );

    assign act_ir   = head_data[SR_W +: IR_W];
    assign act_jdo  = head_data[SR_W-1:0];
    assign act_take = head_data[TAKE_BIT];

endmodule

// File: doc/nios_jtag_debug_sysclk_dec.md
NIOS_JTAG_DEBUG_SYSCLK_DEC -- requirements
Module: nios_jtag_debug_sysclk_dec

Interface
REQ-001 Parameters SHALL be as follows (name, default, meaning):
- SR_W, 38: debug shift-register / jdo width.
- IR_W, 2: virtual-JTAG instruction width.
- SYNC_STAGES, 2: synchroniser depth, minimum 2.
- DEPTH, 4: action FIFO depth, power of 2, minimum 2.
- TAKE_BIT, 34: jdo bit selecting take-action versus no-action.
REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-high reset.
- sr, in, SR_W: TCK-domain shift-register contents, stable while vs_udr is high.
- ir_in, in, IR_W: TCK-domain instruction, stable while vs_udr is high.
- vs_udr, in, 1: asynchronous update-DR level.
- vs_uir, in, 1: asynchronous update-IR level.
- act_ready, in, 1: consumer accepts the FIFO head.
- ovf_clr, in, 1: clears ovf.
- jdo, out, SR_W: last captured sr.
- act_valid, out, 1: FIFO non-empty.
- act_ir, out, IR_W: head instruction.
- act_jdo, out, SR_W: head data.
- act_take, out, 1: head data bit TAKE_BIT.
- ir_upd, out, 1: one-cycle pulse on each update-IR.
- ovf, out, 1: sticky flag, set when an action is dropped.
- level, out, $clog2(DEPTH)+1: FIFO occupancy.

Function
REQ-003 vs_udr and vs_uir SHALL each pass through a SYNC_STAGES-deep flop chain before use.
REQ-004 A rising edge on synchronised udr SHALL be detected in cycle E, at most SYNC_STAGES+1 clk cycles after vs_udr rises.
REQ-005 In cycle E the block SHALL register jdo<=sr and push {ir_in, sr} into the FIFO; jdo SHALL be valid from E+1.
REQ-006 The FIFO SHALL be show-ahead: act_valid, act_ir, act_jdo and act_take SHALL reflect the head from E+1 when the FIFO was empty.
REQ-007 A pop SHALL occur in any cycle where act_valid and act_ready are both 1; act_ready with act_valid=0 SHALL have no effect.
REQ-008 A push when level==DEPTH without a simultaneous pop SHALL be dropped; FIFO contents and jdo SHALL be unchanged, and ovf SHALL be set the next cycle.
REQ-009 A push and pop in the same cycle when full SHALL both complete, leaving level unchanged.
REQ-010 A push and pop in the same cycle when empty SHALL complete with a one-cycle latency to act_valid; there SHALL be no fall-through.
REQ-011 ovf SHALL stay set until ovf_clr; if ovf_clr and a drop coincide, set SHALL win.
REQ-012 A rising edge on synchronised uir SHALL produce ir_upd=1 for exactly one cycle; it SHALL not affect the FIFO.
REQ-013 An edge detector SHALL be armed only after its synchronised input has been sampled low at least once since reset; a level held high across reset release SHALL produce no event.
REQ-014 udr pulses narrower than SYNC_STAGES clk periods are unsupported; each udr high/low phase SHALL last at least SYNC_STAGES+1 clk cycles.
REQ-015 FIFO read/write pointers SHALL wrap modulo DEPTH; level SHALL be computed from pointers one bit wider than log2(DEPTH).

Reset
REQ-016 While reset is asserted, the following SHALL hold: synchroniser flops 0, edge detectors disarmed, jdo=0, FIFO empty (level=0, act_valid=0, act_ir=0, act_jdo=0, act_take=0), ir_upd=0, ovf=0.
REQ-017 Reset asserted mid-operation SHALL discard all FIFO entries immediately (asynchronously); no ir_upd or act_valid pulse SHALL emerge after reset deassertion until a new qualified edge occurs.

Structure
REQ-018 A shared package nios_jtag_dbg_pkg SHALL hold the default parameter constants and the IR encodings (OCIMEM=0, TRACEMEM=1, BREAK=2, TRACECTRL=3).
REQ-019 The FIFO SHALL be a separate sub-module, nios_jtag_dbg_act_fifo, parametrised by width (IR_W+SR_W) and DEPTH; synchronisers and edge detection SHALL stay in the top module.

Verification
REQ-020 Scenario, single update: sr=38'h2_1234_5678, ir_in=2, vs_udr pulsed for 6 cycles -> jdo=38'h2_1234_5678 within SYNC_STAGES+2 cycles; act_valid=1, act_ir=2, act_take=0; pop on act_ready -> level=0.
REQ-021 Scenario, overflow: 5 updates with act_ready=0, DEPTH=4 -> level=4, ovf=1, head equals the first sr; ovf_clr -> ovf=0 next cycle.
REQ-022 Scenario, full with simultaneous pop: FIFO full, act_ready=1 held while a 5th update arrives -> level stays 4, ovf=0, entries 2..5 retained in order.
REQ-023 Scenario, reset release with vs_udr and vs_uir held high: -> no act_valid and no ir_upd; after both drop and rise again -> exactly one entry and one ir_upd pulse.
REQ-024 Scenario, mid-operation reset: reset asserted with level=3 -> level=0 and act_valid=0 in the same cycle, jdo=0.
REQ-025 Scenario, parameter sweep: SR_W=46, IR_W=3, SYNC_STAGES=3, DEPTH=8 -> REQ-020 and REQ-021 pass, with detection latency at most 4 cycles.
